riscv_test_monitor: RTL and testbench
=====================================

Name: riscv_test_monitor

Overview:
Synthesizable end-of-test monitor and reset sequencer for the single-cycle RISC-V core (clk/reset, pc, aluresult, writedata). It sequences core reset, counts run cycles, detects a store to the "tohost" address to decide pass or fail, and flags timeout and hang conditions. It sits beside TOP_RISC in simulation and FPGA builds, so benches become self-checking and no longer rely on fixed-delay stimulus.

Parameters:
XLEN, 32, data/address width of the monitored buses
TOHOST_ADDR, 32'h0000_0064, store address that ends the test
PASS_VALUE, 32'd25, writedata value meaning pass; any other value means fail
RESET_CYCLES, 4, cycles core_reset is held after reset deasserts (>=1)
TIMEOUT_CYCLES, 10000, run cycles before timeout (>=2)
CNT_W, 32, width of cycle_count and store_count
STALL_LIMIT, 8, consecutive cycles with unchanged pc that count as a hang (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high system reset
core_reset  out  1  active-high reset driven to the core
pc  in  XLEN  core program counter
aluresult  in  XLEN  core ALU result (store address when memwrite=1)
writedata  in  XLEN  core store data
memwrite  in  1  core data-memory write enable
done  out  1  test finished (pass, fail, timeout or hang)
pass  out  1  tohost written with PASS_VALUE
fail  out  1  tohost written with another value
timeout  out  1  TIMEOUT_CYCLES elapsed with no tohost write
hang  out  1  pc stuck (optional feature only; otherwise tied 0)
result_data  out  XLEN  writedata captured on the tohost store
cycle_count  out  CNT_W  RUN cycles elapsed
store_count  out  CNT_W  non-tohost stores seen in RUN

Behaviour:
- All outputs are registered. Reset values: state=HOLD, core_reset=1, done/pass/fail/timeout/hang=0, result_data=0, counters=0, hold counter=0.
- FSM states: HOLD, RUN, PASS, FAIL, TIMEOUT, HANG.
- HOLD: core_reset=1. The hold counter increments each cycle with reset=0. When it reaches RESET_CYCLES-1, the FSM moves to RUN and core_reset drops on the same edge. Bus inputs are ignored in HOLD.
- RUN: cycle_count increments every cycle and saturates at all-ones.
- Tohost store (memwrite=1 and aluresult==TOHOST_ADDR), with exact XLEN compare:
  - writedata==PASS_VALUE: go to PASS.
  - Otherwise: go to FAIL.
  - In both cases result_data<=writedata and the matching flag plus done assert on the next edge, so latency is 1 cycle.
- Store to any other address: store_count+1, saturating.
- Timeout: if cycle_count==TIMEOUT_CYCLES-1 and no tohost store occurs that cycle, go to TIMEOUT next edge with timeout=1 and done=1.
- Priority in the same cycle: tohost store > hang > timeout.
- Terminal states (PASS/FAIL/TIMEOUT/HANG):
  - Sticky until reset.
  - core_reset re-asserts to freeze the core.
  - Counters and result_data freeze.
  - Exactly one of pass/fail/timeout/hang is 1.
- Reset asserted in any state, including mid-RUN: the next edge returns all state to reset values. Reset has priority over every event.
- Width rules: compares are unsigned. TIMEOUT_CYCLES must fit in CNT_W; an elaboration check stops with an error otherwise.

Optional Feature:
Macro RISCV_MON_HANG_EN.
- Defined:
  - A stall counter compares pc against pc registered in the previous RUN cycle; equal increments it, different clears it.
  - When the counter reaches STALL_LIMIT-1 with pc still equal, the FSM goes to HANG and hang=1, done=1.
  - This catches the "j ." end loop when software never writes tohost.
- Undefined: no stall logic is built, hang is tied 0, and the HANG state is unreachable.

Decomposition:
- Package riscv_tb_pkg:
  - FSM state enum (mon_state_t).
  - Default TOHOST_ADDR and PASS_VALUE constants.
  - XLEN default.
- Sub-module: rst_sequencer, containing the HOLD counter and core_reset generation. It is reused by future multi-core benches.
- Counters and the FSM stay in riscv_test_monitor.

Test Plan:
1. Pass path:
   - Stimulus: reset=1 for 2 cycles, RESET_CYCLES=4; memwrite=1, aluresult=0x64, writedata=25 at run cycle 10.
   - Response: core_reset low exactly 4 cycles after reset drops; pass=1, done=1 one cycle later; result_data=25, cycle_count=11.
2. Fail path:
   - Stimulus: tohost store with writedata=7; earlier stores to 0x60 and 0x68.
   - Response: fail=1, pass=0, result_data=7, store_count=2, core_reset=1.
3. Timeout path:
   - Stimulus: TIMEOUT_CYCLES=50, no tohost store.
   - Response: timeout=1, done=1 after cycle_count reaches 49; counters freeze.
4. Tohost/timeout collision:
   - Stimulus: tohost pass store in the same cycle cycle_count==49.
   - Response: pass=1, timeout=0.
5. Reset mid-run:
   - Stimulus: assert reset at run cycle 20, release, then rerun the pass path.
   - Response: all outputs return to reset values on the next edge; the second run gives pass with cycle_count restarted from 0.
6. Hang (RISCV_MON_HANG_EN defined):
   - Stimulus: STALL_LIMIT=8, pc held at 0x40 from run cycle 5.
   - Response: hang=1, done=1 when the 8th consecutive equal-pc cycle is reached.
   - With the macro undefined, the same stimulus ends in timeout=1.

Source files
------------

// File: rtl/riscv_tb_pkg.sv
// Shared types and default constants for the RISC-V end-of-test monitor.
//   mon_state_t     : monitor FSM state encoding
//   XLEN_DEF        : default bus width
//   TOHOST_ADDR_DEF : default store address that ends a test
//   PASS_VALUE_DEF  : default store value that means pass
package riscv_tb_pkg;

  localparam int unsigned XLEN_DEF        = 32;
  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_0064;
  localparam logic [31:0] PASS_VALUE_DEF  = 32'd25;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } mon_state_t;

  // True for the sticky end-of-test states.
  function automatic logic is_terminal(input mon_state_t s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) || (s == ST_HANG);
  endfunction

endpackage

// File: rtl/riscv_test_monitor_rst_sequencer.sv
// Core reset sequencer: holds core reset for RESET_CYCLES cycles after the
// system reset drops, then releases it; re-asserts it on a freeze request.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_freeze       : re-assert core reset (test has ended)
//   o_core_reset   : registered active-high reset to the core
//   o_release_c    : combinational, high in the last hold cycle
module rst_sequencer #(
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_freeze,
  output logic o_core_reset,
  output logic o_release_c
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("rst_sequencer: RESET_CYCLES must be >= 1");
  end

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_holding;
  logic              r_core_reset;

  assign o_release_c  = r_holding && (r_hold_cnt == HOLD_LAST);
  assign o_core_reset = r_core_reset;

  // Hold counter and core reset generation.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold_cnt   <= '0;
      r_holding    <= 1'b1;
      r_core_reset <= 1'b1;
    end else if (r_holding) begin
      if (o_release_c) begin
        r_holding    <= 1'b0;
        r_core_reset <= 1'b0;
      end else begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end else if (i_freeze) begin
      r_core_reset <= 1'b1;
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for the single-cycle RISC-V core. Sequences core reset,
// counts run cycles, decides pass/fail from a store to tohost, flags timeout
// and (optionally) a stuck pc.
// Optional feature: define RISCV_MON_HANG_EN to build the pc stall detector;
// without it hang is tied 0 and the HANG state is unreachable.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   core_reset                  : reset driven to the core
//   pc, aluresult, writedata    : monitored core buses
//   memwrite                    : core data-memory write enable
//   done/pass/fail/timeout/hang : test outcome flags (sticky)
//   result_data                 : store data captured on the tohost write
//   cycle_count, store_count    : RUN cycles, non-tohost stores
module riscv_test_monitor
  import riscv_tb_pkg::*;
#(
  parameter int unsigned         XLEN           = XLEN_DEF,
  parameter logic [XLEN-1:0]     TOHOST_ADDR    = XLEN'(TOHOST_ADDR_DEF),
  parameter logic [XLEN-1:0]     PASS_VALUE     = XLEN'(PASS_VALUE_DEF),
  parameter int unsigned         RESET_CYCLES   = 4,
  parameter int unsigned         TIMEOUT_CYCLES = 10000,
  parameter int unsigned         CNT_W          = 32,
  parameter int unsigned         STALL_LIMIT    = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             core_reset,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  aluresult,
  input  logic [XLEN-1:0]  writedata,
  input  logic             memwrite,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             hang,
  output logic [XLEN-1:0]  result_data,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] store_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if ((64'(TIMEOUT_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_timeout_width
    $error("riscv_test_monitor: TIMEOUT_CYCLES does not fit in CNT_W");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("riscv_test_monitor: TIMEOUT_CYCLES must be >= 2");
  end
  if (STALL_LIMIT < 1) begin : g_bad_stall
    $error("riscv_test_monitor: STALL_LIMIT must be >= 1");
  end

  mon_state_t       r_state;
  mon_state_t       w_state_nxt;
  logic             w_release_c;
  logic             w_freeze;
  logic             w_tohost;
  logic             w_timeout_hit;
  logic             w_hang_hit;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic [XLEN-1:0]  r_result_data;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_store_count;

  // Freeze the core on the edge that leaves RUN for a terminal state.
  assign w_freeze = (r_state == ST_RUN) && is_terminal(w_state_nxt);

  rst_sequencer #(
    .RESET_CYCLES (RESET_CYCLES)
  ) u_rst_sequencer (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_freeze     (w_freeze),
    .o_core_reset (core_reset),
    .o_release_c  (w_release_c)
  );

  assign w_tohost      = memwrite && (aluresult == TOHOST_ADDR);
  assign w_timeout_hit = (r_cycle_count == TIMEOUT_LAST);

`ifdef RISCV_MON_HANG_EN
  localparam int unsigned STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  logic [XLEN-1:0]    r_pc_prev;
  logic               r_pc_valid;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_hang;
  logic               w_pc_same;

  // The first RUN cycle has no previous pc to compare against.
  assign w_pc_same  = r_pc_valid && (pc == r_pc_prev);
  assign w_hang_hit = w_pc_same && (r_stall_cnt == STALL_LAST);
  assign hang       = r_hang;

  // Stall detector: counts consecutive RUN cycles with an unchanged pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_prev   <= '0;
      r_pc_valid  <= 1'b0;
      r_stall_cnt <= '0;
      r_hang      <= 1'b0;
    end else begin
      r_hang <= (w_state_nxt == ST_HANG);
      if (r_state == ST_RUN) begin
        r_pc_prev   <= pc;
        r_pc_valid  <= 1'b1;
        r_stall_cnt <= w_pc_same ? (r_stall_cnt + STALL_W'(1)) : '0;
      end
    end
  end
`else
  logic w_unused_pc;

  assign w_unused_pc = ^pc;
  assign w_hang_hit  = 1'b0;
  assign hang        = 1'b0;
`endif

  // Next-state logic; tohost store wins over hang, hang over timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HOLD: begin
        if (w_release_c) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_tohost)          w_state_nxt = (writedata == PASS_VALUE) ? ST_PASS : ST_FAIL;
        else if (w_hang_hit)   w_state_nxt = ST_HANG;
        else if (w_timeout_hit) w_state_nxt = ST_TIMEOUT;
      end
      default: ;
    endcase
  end

  // State, outcome flags and counters; everything freezes outside RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_HOLD;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_result_data <= '0;
      r_cycle_count <= '0;
      r_store_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= is_terminal(w_state_nxt);
      r_pass    <= (w_state_nxt == ST_PASS);
      r_fail    <= (w_state_nxt == ST_FAIL);
      r_timeout <= (w_state_nxt == ST_TIMEOUT);
      if (r_state == ST_RUN) begin
        if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + CNT_W'(1);
        if (w_tohost) begin
          r_result_data <= writedata;
        end else if (memwrite && (r_store_count != '1)) begin
          r_store_count <= r_store_count + CNT_W'(1);
        end
      end
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign result_data = r_result_data;
  assign cycle_count = r_cycle_count;
  assign store_count = r_store_count;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: the driver builds a per-cycle bus
// program, predicts the outcome from it and queues the prediction; a monitor
// pops and compares when done rises, and again a few cycles later.
module tb_riscv_test_monitor;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned RC    = 4;
  localparam int unsigned TC    = 50;
  localparam int unsigned SL    = 8;
  localparam int          LEN   = 60;
  localparam logic [31:0] TOHOST = 32'h0000_0064;
  localparam logic [31:0] PV     = 32'd25;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             core_reset;
  logic [XLEN-1:0]  pc = '0;
  logic [XLEN-1:0]  aluresult = '0;
  logic [XLEN-1:0]  writedata = '0;
  logic             memwrite = 1'b0;
  logic             done, pass, fail, timeout, hang;
  logic [XLEN-1:0]  result_data;
  logic [CNT_W-1:0] cycle_count, store_count;

  always #5 clk = ~clk;

  riscv_test_monitor #(
    .XLEN           (XLEN),
    .TOHOST_ADDR    (TOHOST),
    .PASS_VALUE     (PV),
    .RESET_CYCLES   (RC),
    .TIMEOUT_CYCLES (TC),
    .CNT_W          (CNT_W),
    .STALL_LIMIT    (SL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_reset  (core_reset),
    .pc          (pc),
    .aluresult   (aluresult),
    .writedata   (writedata),
    .memwrite    (memwrite),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .hang        (hang),
    .result_data (result_data),
    .cycle_count (cycle_count),
    .store_count (store_count)
  );

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        hang;
    logic [31:0] result;
    logic [31:0] cycles;
    logic [31:0] stores;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] v_pc[LEN];
  logic [31:0] v_al[LEN];
  logic [31:0] v_wd[LEN];
  bit          v_mw[LEN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic compare_outcome(input string tag, input exp_t e);
    check({tag, ".pass"},        32'(pass),        32'(e.pass));
    check({tag, ".fail"},        32'(fail),        32'(e.fail));
    check({tag, ".timeout"},     32'(timeout),     32'(e.timeout));
    check({tag, ".hang"},        32'(hang),        32'(e.hang));
    check({tag, ".done"},        32'(done),        32'd1);
    check({tag, ".core_reset"},  32'(core_reset),  32'd1);
    check({tag, ".result_data"}, result_data,      e.result);
    check({tag, ".cycle_count"}, cycle_count,      e.cycles);
    check({tag, ".store_count"}, store_count,      e.stores);
  endtask

  // Outcome of a bus program, walking the cycles in order with the monitor's rules.
  function automatic exp_t model(input int len);
    exp_t e;
    int   sc;
    int   eqrun;
    bit   eq;
    e     = '0;
    sc    = 0;
    eqrun = 0;
    for (int i = 0; i < len; i++) begin
      eq = 1'b0;
      if (i > 0) eq = (v_pc[i] == v_pc[i-1]);
      eqrun = eq ? eqrun + 1 : 0;
      if (v_mw[i] && v_al[i] == TOHOST) begin
        e.pass   = (v_wd[i] == PV);
        e.fail   = (v_wd[i] != PV);
        e.result = v_wd[i];
        e.cycles = 32'(i + 1);
        e.stores = 32'(sc);
        return e;
      end
      if (v_mw[i]) sc++;
`ifdef RISCV_MON_HANG_EN
      if (eqrun == int'(SL)) begin
        e.hang   = 1'b1;
        e.cycles = 32'(i + 1);
        e.stores = 32'(sc);
        return e;
      end
`endif
      if (i + 1 == int'(TC)) begin
        e.timeout = 1'b1;
        e.cycles  = 32'(i + 1);
        e.stores  = 32'(sc);
        return e;
      end
    end
    return e;
  endfunction

  // Fill the bus program; tohost_at<0 means no tohost store, hold_from>=0 parks pc at 0x40.
  task automatic build(input int tohost_at, input bit pass_val, input int hold_from, input bit quiet);
    logic [31:0] a;
    for (int i = 0; i < LEN; i++) begin
      if (i == 0)                              v_pc[i] = 32'h0;
      else if (hold_from >= 0 && i >= hold_from) v_pc[i] = 32'h40;
      else if (!quiet && hold_from < 0 && ($urandom % 6) == 0) v_pc[i] = v_pc[i-1];
      else                                     v_pc[i] = v_pc[i-1] + 32'd4;
      case ($urandom % 4)
        0:       a = 32'h60;
        1:       a = 32'h68;
        2:       a = TOHOST ^ (32'd1 << ($urandom % 32));
        default: a = $urandom;
      endcase
      if (a == TOHOST) a = a + 32'd4;
      v_al[i] = a;
      v_mw[i] = !quiet && (($urandom % 4) == 0);
      v_wd[i] = $urandom;
      if (i == tohost_at) begin
        v_mw[i] = 1'b1;
        v_al[i] = TOHOST;
        v_wd[i] = pass_val ? PV : $urandom;
        if (!pass_val && v_wd[i] == PV) v_wd[i] = PV ^ 32'd1;
      end
    end
  endtask

  task automatic drive(input int i);
    pc        = v_pc[i];
    memwrite  = v_mw[i];
    aluresult = v_al[i];
    writedata = v_wd[i];
  endtask

  // Reset, check reset values, then measure the core reset hold while offering ignored stores.
  task automatic do_reset();
    int n;
    reset = 1'b1;
    memwrite = 1'b0; pc = '0; aluresult = '0; writedata = '0;
    @(posedge clk); #1;
    check("rst.core_reset",  32'(core_reset), 32'd1);
    check("rst.done",        32'(done),       32'd0);
    check("rst.flags",       32'({pass, fail, timeout, hang}), 32'd0);
    check("rst.result_data", result_data,     32'd0);
    check("rst.cycle_count", cycle_count,     32'd0);
    check("rst.store_count", store_count,     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    memwrite = 1'b1; aluresult = TOHOST; writedata = 32'd7;
    n = 0;
    while (core_reset === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold.cycles",      32'(n),        32'(RC));
    check("hold.cycle_count", cycle_count,   32'd0);
    check("hold.done",        32'(done),     32'd0);
  endtask

  task automatic run_vec(input int len);
    exp_q.push_back(model(len));
    for (int i = 0; i < len; i++) begin
      drive(i);
      @(posedge clk); #1;
      if (done) break;
    end
    if (!done) begin
      check("done_seen", 32'(done), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    // Post-test traffic, including tohost stores, must not disturb the frozen result.
    repeat (6) begin
      pc        = $urandom;
      memwrite  = 1'($urandom % 2);
      aluresult = (($urandom % 2) == 0) ? TOHOST : $urandom;
      writedata = $urandom;
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare on the rising edge of done, then recheck after a few cycles.
  initial begin : monitor
    exp_t e;
    exp_t cur;
    logic done_q;
    int   freeze_t;
    done_q   = 1'b0;
    freeze_t = 0;
    cur      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_q   = 1'b0;
        freeze_t = 0;
      end else begin
        if (done && !done_q) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e   = exp_q.pop_front();
            cur = e;
            compare_outcome("at_done", e);
            freeze_t = 4;
          end
        end else if (freeze_t > 0) begin
          freeze_t--;
          if (freeze_t == 0) compare_outcome("frozen", cur);
        end
        done_q = done;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int t_at;
    int hold;
    // Pass path: tohost=25 at run cycle 10.
    do_reset(); build(10, 1'b1, -1, 1'b1); run_vec(LEN);
    // Fail path: stores to 0x60 and 0x68 first, then tohost=7.
    do_reset(); build(12, 1'b0, -1, 1'b1);
    v_mw[3] = 1'b1; v_al[3] = 32'h60;
    v_mw[6] = 1'b1; v_al[6] = 32'h68;
    v_wd[12] = 32'd7;
    run_vec(LEN);
    // Timeout path.
    do_reset(); build(-1, 1'b0, -1, 1'b0); run_vec(LEN);
    // Tohost pass store in the same cycle as the timeout.
    do_reset(); build(TC - 1, 1'b1, -1, 1'b0); run_vec(LEN);
    // Reset in the middle of a run, then the pass path again.
    do_reset(); build(-1, 1'b0, -1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(i);
      @(posedge clk); #1;
    end
    check("midrun.cycle_count", cycle_count, 32'd20);
    do_reset(); build(10, 1'b1, -1, 1'b1); run_vec(LEN);
    // pc parked at 0x40 from run cycle 5: hang if the detector is built, else timeout.
    do_reset(); build(-1, 1'b0, 5, 1'b1); run_vec(LEN);
    // Randomized programs.
    for (int k = 0; k < 14; k++) begin
      t_at = (($urandom % 4) == 0) ? -1 : int'($urandom_range(0, LEN - 1));
      hold = (($urandom % 4) == 0) ? int'($urandom_range(1, 40)) : -1;
      do_reset(); build(t_at, 1'($urandom % 2), hold, 1'b0); run_vec(LEN);
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
